// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with req/ack handshake
//
// Purpose: accepts one load/store/fetch request at a time, waits WAIT_CYCLES
// states, then reads or writes an internal word array and returns a one-cycle
// ack with read data and an error flag for out-of-range (or protected) accesses.
//
// Optional feature macro: MEM_WRITE_PROTECT_EN
//   defined   - writes with addr < PROT_LIMIT are rejected with err=1
//   undefined - every in-range write succeeds
//
// Ports:
//   clk    in   1       clock, rising edge
//   rst    in   1       asynchronous reset, active-high
//   req    in   1       request valid, sampled only in IDLE
//   we     in   1       1 = write, 0 = read
//   addr   in   ADDR_W  word address
//   wdata  in   DATA_W  write data
//   ack    out  1       one-cycle completion strobe
//   rdata  out  DATA_W  read data, held until the next completion
//   err    out  1       access rejected, held until the next completion
//   busy   out  1       high whenever not IDLE
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_LIMIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // Access operands: with zero wait states the access happens on the
  // acceptance edge, so the live inputs are used instead of the latched copy.
  logic              acc_en;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic              reject;
  logic              mem_wr;
  logic [IDX_W-1:0]  acc_idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d      = we;
          addr_d    = addr;
          wdata_d   = wdata;
          acc_we    = we;
          acc_addr  = addr;
          acc_wdata = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            acc_en  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Range check on the full address before any truncation to the index.
    in_range = ({1'b0, acc_addr} < DEPTH_LIM);
`ifdef MEM_WRITE_PROTECT_EN
    reject = acc_we && ({1'b0, acc_addr} < (ADDR_W + 1)'(PROT_LIMIT));
`else
    reject = 1'b0;
`endif
    acc_idx = acc_addr[IDX_W-1:0];
    mem_wr  = acc_en && in_range && acc_we && !reject;

    if (acc_en) begin
      if (!in_range || reject) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else if (acc_we) begin
        rdata_d = '0;
        err_d   = 1'b0;
      end else begin
        rdata_d = mem[acc_idx];
        err_d   = 1'b0;
      end
    end
  end

`ifndef MEM_WRITE_PROTECT_EN
  logic unused_prot_limit;
  assign unused_prot_limit = (PROT_LIMIT != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign ack   = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
